// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Sequences one multiplexed address/data RTC bus transaction (read or
//   write) per start pulse. First an address phase with a strobe, then an
//   address hold, then a data phase with a strobe, then a recovery phase.
//   A single-cycle completion pulse ends the transaction.
//
// Parameters
//   T_PULSE  width in clk cycles of each CS/strobe-active phase (1..255)
//   T_GAP    width in clk cycles of each hold/recovery phase   (1..255)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start_rd   read request pulse
//   start_wr   write request pulse (wins over start_rd)
//   addr       RTC register address, latched at acceptance
//   wdata      write data, latched at acceptance
//   RTC_out    data read back from the RTC bus
//   RTC_in     value driven onto the RTC bus
//   bus_oe     1 = FPGA drives RTC_in onto the bus
//   A_D        0 = address phase, 1 = data phase
//   CS, RD, WR active-low chip select / read strobe / write strobe
//   rdata      last captured read data
//   busy       high from acceptance through DONE
//   listo      single-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | bus released, waiting for a start pulse
// ADDR      | address driven, CS and WR low (T_PULSE cycles)
// ADDR_HOLD | address held, strobes high (T_GAP cycles)
// DATA      | data phase, CS plus RD or WR low (T_PULSE cycles)
// RECOVER   | strobes high, write data held (T_GAP cycles)
// DONE      | one cycle, listo pulse

module rtc_bus_sequencer #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_rd,
  input  logic       start_wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] RTC_out,
  output logic [7:0] RTC_in,
  output logic       bus_oe,
  output logic       A_D,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       listo
);

  // The counter is loaded with the phase length minus one on entry and the
  // phase ends on the cycle it reads zero.
  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_HOLD, DATA, RECOVER, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       op_wr, op_wr_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic [7:0] rdata_nxt;

  logic [7:0] rtc_in_nxt;
  logic       bus_oe_nxt, a_d_nxt, cs_nxt, rd_nxt, wr_nxt, busy_nxt, listo_nxt;

  // Next-state, counter and request latch.
  always_comb begin
    state_nxt = state;
    op_wr_nxt = op_wr;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;

    case (state)
      IDLE: begin
        if (start_rd || start_wr) begin
          state_nxt = ADDR;
          op_wr_nxt = start_wr;
          addr_nxt  = addr;
          wdata_nxt = wdata;
        end
      end
      ADDR:      if (cnt == 8'd0) state_nxt = ADDR_HOLD;
      ADDR_HOLD: if (cnt == 8'd0) state_nxt = DATA;
      DATA: begin
        if (cnt == 8'd0) begin
          state_nxt = RECOVER;
          if (!op_wr) rdata_nxt = RTC_out;
        end
      end
      RECOVER:   if (cnt == 8'd0) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      case (state_nxt)
        ADDR, DATA:         cnt_nxt = PULSE_LD;
        ADDR_HOLD, RECOVER: cnt_nxt = GAP_LD;
        default:            cnt_nxt = 8'd0;
      endcase
    end else if (cnt != 8'd0) begin
      cnt_nxt = cnt - 8'd1;
    end
  end

  // Bus outputs are decoded from the upcoming state and registered, so the
  // pins come straight from flops and change exactly on phase boundaries.
  always_comb begin
    rtc_in_nxt = 8'h00;
    bus_oe_nxt = 1'b0;
    a_d_nxt    = 1'b1;
    cs_nxt     = 1'b1;
    rd_nxt     = 1'b1;
    wr_nxt     = 1'b1;
    busy_nxt   = 1'b1;
    listo_nxt  = 1'b0;

    case (state_nxt)
      IDLE: busy_nxt = 1'b0;
      ADDR: begin
        a_d_nxt    = 1'b0;
        cs_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        bus_oe_nxt = 1'b1;
        rtc_in_nxt = addr_nxt;
      end
      ADDR_HOLD: begin
        a_d_nxt    = 1'b0;
        bus_oe_nxt = 1'b1;
        rtc_in_nxt = addr_nxt;
      end
      DATA: begin
        cs_nxt = 1'b0;
        if (op_wr_nxt) begin
          wr_nxt     = 1'b0;
          bus_oe_nxt = 1'b1;
          rtc_in_nxt = wdata_nxt;
        end else begin
          rd_nxt = 1'b0;
        end
      end
      RECOVER: begin
        if (op_wr_nxt) begin
          bus_oe_nxt = 1'b1;
          rtc_in_nxt = wdata_nxt;
        end
      end
      DONE:    listo_nxt = 1'b1;
      default: busy_nxt  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      op_wr   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata   <= 8'h00;
      RTC_in  <= 8'h00;
      bus_oe  <= 1'b0;
      A_D     <= 1'b1;
      CS      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      busy    <= 1'b0;
      listo   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_wr   <= op_wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata   <= rdata_nxt;
      RTC_in  <= rtc_in_nxt;
      bus_oe  <= bus_oe_nxt;
      A_D     <= a_d_nxt;
      CS      <= cs_nxt;
      RD      <= rd_nxt;
      WR      <= wr_nxt;
      busy    <= busy_nxt;
      listo   <= listo_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: a default-parameter instance and a
// T_PULSE=1/T_GAP=1 instance. Every cycle the observed pin vector is
// compared against a phase model derived from the cycle index. Completion
// records are pushed to a scoreboard at request time and popped on listo.

module tb_rtc_bus_sequencer;

  localparam int P0 = 10, G0 = 5;
  localparam int P1 = 1,  G1 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_rd, start_wr;
  logic [7:0] addr, wdata, rtc_out;
  bit         sel;

  logic [7:0] rtc_in0, rdata0, rtc_in1, rdata1;
  logic       oe0, ad0, cs0, rd0, wr0, busy0, listo0;
  logic       oe1, ad1, cs1, rd1, wr1, busy1, listo1;
  logic       s_rd0, s_wr0, s_rd1, s_wr1;

  assign s_rd0 = start_rd & ~sel;
  assign s_wr0 = start_wr & ~sel;
  assign s_rd1 = start_rd & sel;
  assign s_wr1 = start_wr & sel;

  rtc_bus_sequencer #(.T_PULSE(P0), .T_GAP(G0)) dut (
    .clk(clk), .reset(reset), .start_rd(s_rd0), .start_wr(s_wr0),
    .addr(addr), .wdata(wdata), .RTC_out(rtc_out), .RTC_in(rtc_in0),
    .bus_oe(oe0), .A_D(ad0), .CS(cs0), .RD(rd0), .WR(wr0),
    .rdata(rdata0), .busy(busy0), .listo(listo0));

  rtc_bus_sequencer #(.T_PULSE(P1), .T_GAP(G1)) dut1 (
    .clk(clk), .reset(reset), .start_rd(s_rd1), .start_wr(s_wr1),
    .addr(addr), .wdata(wdata), .RTC_out(rtc_out), .RTC_in(rtc_in1),
    .bus_oe(oe1), .A_D(ad1), .CS(cs1), .RD(rd1), .WR(wr1),
    .rdata(rdata1), .busy(busy1), .listo(listo1));

  always #5 clk = ~clk;

  // {A_D, CS, RD, WR, bus_oe, busy, listo, RTC_in, rdata}
  logic [22:0] v0, v1, obs;
  assign v0  = {ad0, cs0, rd0, wr0, oe0, busy0, listo0, rtc_in0, rdata0};
  assign v1  = {ad1, cs1, rd1, wr1, oe1, busy1, listo1, rtc_in1, rdata1};
  assign obs = sel ? v1 : v0;

  typedef struct {
    int         cyc;
    logic [7:0] rd;
  } sb_t;
  sb_t sb_q[$];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_rd [2];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] idle_vec(input logic [7:0] rdv);
    return {7'b1111000, 8'h00, rdv};
  endfunction

  function automatic logic [22:0] exp_vec(input int c, input int p, input int g,
      input bit w, input logic [7:0] a, input logic [7:0] d,
      input logic [7:0] old_rd, input logic [7:0] new_rd);
    logic [7:0] rdv;
    rdv = (!w && c >= 2*p + g + 1) ? new_rd : old_rd;
    if (c >= 1 && c <= p)
      return {7'b0010110, a, rdv};
    else if (c <= p + g)
      return {7'b0111110, a, rdv};
    else if (c <= 2*p + g)
      return w ? {7'b1010110, d, rdv} : {7'b1001010, 8'h00, rdv};
    else if (c <= 2*p + 2*g)
      return w ? {7'b1111110, d, rdv} : {7'b1111010, 8'h00, rdv};
    else if (c == 2*p + 2*g + 1)
      return {7'b1111011, 8'h00, rdv};
    else
      return idle_vec(rdv);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle", 32'(obs), 32'(idle_vec(exp_rd[sel])));
    end
  endtask

  // rd/wr: request pulses; r: value held on RTC_out; inj: cycle in which a
  // stray start_rd is pulsed; rst_at: cycle in which reset is asserted.
  task automatic run_txn(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] r,
                         input int inj, input int rst_at);
    int         p, g, total;
    bit         w;
    logic [7:0] old_rd, new_rd;
    sb_t        e, s;
    p      = sel ? P1 : P0;
    g      = sel ? G1 : G0;
    total  = 2*p + 2*g + 1;
    w      = wr;
    old_rd = exp_rd[sel];
    new_rd = w ? old_rd : r;
    rtc_out = r;
    @(negedge clk);
    start_rd = rd; start_wr = wr; addr = a; wdata = d;
    if (rst_at == 0) begin
      e.cyc = total; e.rd = new_rd;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 start_rd = 1'b0; start_wr = 1'b0;
    for (int c = 1; c <= total + 3; c++) begin
      @(negedge clk);
      check_val("bus", 32'(obs), 32'(exp_vec(c, p, g, w, a, d, old_rd, new_rd)));
      check_val("excl", 32'((obs[20] == 1'b0 && obs[19] == 1'b0) ||
                            (obs[18] && obs[20] == 1'b0)), 32'd0);
      if (obs[16]) begin
        if (sb_q.size() == 0) begin
          check_val("sb_empty", 32'd1, 32'd0);
        end else begin
          s = sb_q.pop_front();
          check_val("sb_cyc", 32'(c), 32'(s.cyc));
          check_val("sb_rdata", 32'(obs[7:0]), 32'(s.rd));
        end
      end
      if (c == rst_at) begin
        #2 reset = 1'b1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        #1 check_val("rst_async", 32'(obs), 32'(idle_vec(8'h00)));
        @(posedge clk);
        #1 check_val("rst_hold", 32'(obs), 32'(idle_vec(8'h00)));
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(total + 3);
        break;
      end
      if (c == inj) start_rd = 1'b1;
      @(posedge clk);
      #1 start_rd = 1'b0;
    end
    if (rst_at == 0) exp_rd[sel] = new_rd;
    check_val("sb_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start_rd = 1'b0; start_wr = 1'b0;
    addr = 8'h00; wdata = 8'h00; rtc_out = 8'h00; sel = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    #12;
    check_val("reset0", 32'(v0), 32'(idle_vec(8'h00)));
    check_val("reset1", 32'(v1), 32'(idle_vec(8'h00)));
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3);

    run_txn(1'b0, 1'b1, 8'h21, 8'h45, 8'h00, 0, 0);   // write
    idle_cycles(2);
    run_txn(1'b1, 1'b0, 8'h21, 8'h00, 8'h59, 0, 0);   // read
    idle_cycles(2);
    run_txn(1'b1, 1'b1, 8'h33, 8'hC7, 8'h96, 0, 0);   // both: write wins
    run_txn(1'b0, 1'b1, 8'h7E, 8'h81, 8'h00, 12, 0);  // stray start_rd ignored
    idle_cycles(1);
    run_txn(1'b1, 1'b0, 8'h21, 8'h00, 8'hA3, 0, 18);  // reset mid-read
    run_txn(1'b1, 1'b0, 8'h0F, 8'h00, 8'h3C, 0, 0);   // fresh read after reset

    @(negedge clk);
    sel = 1'b1;
    idle_cycles(2);
    run_txn(1'b0, 1'b1, 8'hA5, 8'h5A, 8'h00, 0, 0);
    run_txn(1'b1, 1'b0, 8'h12, 8'h00, 8'hC3, 0, 0);
    run_txn(1'b1, 1'b1, 8'h44, 8'h99, 8'h11, 0, 0);
    check_val("rdata0_final", 32'(rdata0), 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
